// File: rtl/speed_seq_pkg.sv
// Shared types and helpers for the speed sequencer: FSM states, speed codes and
// the code-to-period mapping used to reload the rate divider.
package speed_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FINISH
  } state_t;

  localparam logic [1:0] SPD_FULL = 2'b00;
  localparam logic [1:0] SPD_1HZ  = 2'b01;
  localparam logic [1:0] SPD_HALF = 2'b10;
  localparam logic [1:0] SPD_QTR  = 2'b11;

  // Tick period in clock cycles; callers subtract one for the divider reload value.
  function automatic int unsigned period(input logic [1:0] code, input int unsigned freq);
    case (code)
      SPD_FULL: return 1;
      SPD_1HZ:  return freq;
      SPD_HALF: return 2 * freq;
      default:  return 4 * freq;
    endcase
  endfunction

endpackage

// File: rtl/rate_tick.sv
// Loadable down-counter that emits a tick whenever it reaches zero while running,
// then reloads itself with the last loaded value.
module rate_tick #(
  parameter int W = 4
) (
  input  logic         ClockIn,
  input  logic         Reset,
  input  logic         Load,
  input  logic [W-1:0] LoadValue,
  input  logic         Run,
  output logic         Tick
);

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] reload_q, reload_d;

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    if (Load) begin
      count_d  = LoadValue;
      reload_d = LoadValue;
    end else if (Run) begin
      count_d = (count_q == '0) ? reload_q : count_q - W'(1);
    end
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  assign Tick = Run && (count_q == '0);

endmodule

// File: rtl/speed_sequencer.sv
// Steps through a small program of (speed, dwell) pairs, producing an Enable tick at
// the active rate and counting those ticks into a 4-bit display counter.
module speed_sequencer
  import speed_seq_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int STEPS           = 4,
  parameter int DWELL_W         = 4,
  localparam int StepW          = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic                       ClockIn,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Halt,
  input  logic                       Loop,
  input  logic [2*STEPS-1:0]         ProgSpeed,
  input  logic [DWELL_W*STEPS-1:0]   ProgDwell,
  output logic [1:0]                 Speed,
  output logic                       Enable,
  output logic [StepW-1:0]           Step,
  output logic                       Busy,
  output logic                       Done,
  output logic [3:0]                 CounterValue
);

  localparam int DivW = $clog2(4 * CLOCK_FREQUENCY);
  localparam logic [StepW-1:0] LastStep = StepW'(STEPS - 1);

  state_t               state_q, state_d;
  logic [StepW-1:0]     step_q, step_d;
  logic [1:0]           speed_q, speed_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 busy_q, done_q;

  int unsigned          stepIdx;
  logic [1:0]           curSpeed;
  logic [DWELL_W-1:0]   curDwell;
  logic [DivW-1:0]      reloadValue;
  logic                 divLoad;
  logic                 tick;
  logic                 advance;

  assign stepIdx     = 32'(step_q);
  assign curSpeed    = ProgSpeed[2*stepIdx +: 2];
  assign curDwell    = ProgDwell[DWELL_W*stepIdx +: DWELL_W];
  assign reloadValue = DivW'(period(curSpeed, CLOCK_FREQUENCY) - 1);

  rate_tick #(.W(DivW)) u_rate_tick (
    .ClockIn  (ClockIn),
    .Reset    (Reset),
    .Load     (divLoad),
    .LoadValue(reloadValue),
    .Run      (state_q == RUN),
    .Tick     (tick)
  );

  // Halt wins over everything outside IDLE; skipped steps and finished dwells share
  // one advance path so looping and end-of-program behave identically from LOAD or RUN.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    speed_d = speed_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    divLoad = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start && !Halt) begin
          state_d = LOAD;
          step_d  = '0;
        end
      end
      LOAD: begin
        if (Halt) begin
          state_d = IDLE;
        end else begin
          speed_d = curSpeed;
          divLoad = 1'b1;
          dwell_d = curDwell;
          if (curDwell == '0) advance = 1'b1;
          else                state_d = RUN;
        end
      end
      RUN: begin
        if (Halt) begin
          state_d = IDLE;
        end else if (tick) begin
          cnt_d   = cnt_q + 4'd1;
          dwell_d = dwell_q - DWELL_W'(1);
          if (dwell_q <= DWELL_W'(1)) advance = 1'b1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (advance) begin
      if (step_q < LastStep) begin
        step_d  = step_q + StepW'(1);
        state_d = LOAD;
      end else if (Loop) begin
        step_d  = '0;
        state_d = LOAD;
      end else begin
        state_d = FINISH;
      end
    end
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      speed_q <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      speed_q <= speed_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == LOAD) || (state_d == RUN);
      done_q  <= (state_d == FINISH);
    end
  end

  assign Speed        = speed_q;
  assign Enable       = tick;
  assign Step         = step_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign CounterValue = cnt_q;

endmodule

// File: tb/tb_speed_sequencer.sv
// Randomized self-checking bench for speed_sequencer, comparing every cycle against a
// timeline built from tick periods and dwell counts.
module tb_speed_sequencer;

  localparam int F     = 4;
  localparam int STEPS = 4;
  localparam int DWW   = 4;
  localparam int N     = 1100;

  logic        ClockIn = 1'b0;
  logic        Reset, Start, Halt, Loop;
  logic [7:0]  ProgSpeed;
  logic [15:0] ProgDwell;
  logic [1:0]  Speed;
  logic        Enable;
  logic [1:0]  Step;
  logic        Busy, Done;
  logic [3:0]  CounterValue;

  int errors = 0;
  int checks = 0;
  int mStep = 0, mSpeed = 0, mCnt = 0;
  int expEn[N], expBusy[N], expDone[N], expStep[N], expSpeed[N], expCnt[N];

  speed_sequencer #(.CLOCK_FREQUENCY(F), .STEPS(STEPS), .DWELL_W(DWW)) dut (
    .ClockIn(ClockIn), .Reset(Reset), .Start(Start), .Halt(Halt), .Loop(Loop),
    .ProgSpeed(ProgSpeed), .ProgDwell(ProgDwell), .Speed(Speed), .Enable(Enable),
    .Step(Step), .Busy(Busy), .Done(Done), .CounterValue(CounterValue)
  );

  always #5 ClockIn = ~ClockIn;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %0d expected %0d", tag, $time, observed, expected);
    end
  endtask

  function automatic int periodOf(input int code);
    case (code)
      0:       return 1;
      1:       return F;
      2:       return 2 * F;
      default: return 4 * F;
    endcase
  endfunction

  task automatic put(input int c, input int en, input int busy, input int done,
                     input int step, input int speed, input int cnt);
    expEn[c] = en; expBusy[c] = busy; expDone[c] = done;
    expStep[c] = step; expSpeed[c] = speed; expCnt[c] = cnt;
  endtask

  // Cycle 0 is the first LOAD cycle; each step costs one LOAD cycle plus dwell*P run cycles.
  task automatic buildModel(output int len);
    int c = 0, step = 0, speed = mSpeed, cnt = mCnt, code, dwell, p;
    bit finished = 0;
    while (c < N && !finished) begin
      code  = int'(ProgSpeed[2*step +: 2]);
      dwell = int'(ProgDwell[DWW*step +: DWW]);
      put(c, 0, 1, 0, step, speed, cnt);
      c++;
      speed = code;
      p = periodOf(code);
      for (int j = 1; j <= dwell * p && c < N; j++) begin
        put(c, (j % p == 0) ? 1 : 0, 1, 0, step, speed, cnt);
        if (j % p == 0) cnt = (cnt + 1) % 16;
        c++;
      end
      if (step < STEPS - 1) step++;
      else if (Loop) step = 0;
      else begin
        if (c < N) put(c, 0, 0, 1, step, speed, cnt);
        c++;
        finished = 1;
      end
    end
    len = (c < N) ? c : N;
    for (int k = len; k < N; k++) put(k, 0, 0, 0, step, speed, cnt);
  endtask

  task automatic checkCycle(input int c);
    checkOutput("enable",  32'(Enable),       32'(expEn[c]));
    checkOutput("busy",    32'(Busy),         32'(expBusy[c]));
    checkOutput("done",    32'(Done),         32'(expDone[c]));
    checkOutput("step",    32'(Step),         32'(expStep[c]));
    checkOutput("speed",   32'(Speed),        32'(expSpeed[c]));
    checkOutput("counter", 32'(CounterValue), 32'(expCnt[c]));
  endtask

  task automatic checkIdle(input string tag, input int step, input int speed, input int cnt);
    checkOutput({tag, "_enable"},  32'(Enable),       0);
    checkOutput({tag, "_busy"},    32'(Busy),         0);
    checkOutput({tag, "_done"},    32'(Done),         0);
    checkOutput({tag, "_step"},    32'(Step),         32'(step));
    checkOutput({tag, "_speed"},   32'(Speed),        32'(speed));
    checkOutput({tag, "_counter"}, 32'(CounterValue), 32'(cnt));
  endtask

  // haltMode: 0 none, 1 maybe (random), 2 always within the first haltMax cycles
  task automatic applyStimulus(input bit loopMode, input int haltMode, input int haltMax);
    int len, lim, haltAt;
    @(negedge ClockIn);
    Loop  = loopMode;
    Start = 1'b1;
    Halt  = 1'b0;
    buildModel(len);
    haltAt = -1;
    if (haltMode == 2) haltAt = $urandom_range(2, haltMax);
    else if (haltMode == 1 && ($urandom % 3 == 0)) haltAt = $urandom_range(0, len - 1);
    lim = (haltAt >= 0) ? haltAt : len + 2;
    for (int c = 0; c <= lim; c++) begin
      @(negedge ClockIn);
      checkCycle(c);
      Start = (expBusy[c] == 1) ? 1'($urandom % 2) : 1'b0;
      Halt  = (c == haltAt);
    end
    if (haltAt >= 0) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge ClockIn);
        Start = 1'b0;
        Halt  = 1'b0;
        checkIdle("halt", expStep[haltAt], expSpeed[haltAt], expCnt[haltAt]);
      end
    end
    mStep  = expStep[lim];
    mSpeed = expSpeed[lim];
    mCnt   = expCnt[lim];
    Start  = 1'b0;
    Halt   = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Loop = 1'b0;
    ProgSpeed = '0; ProgDwell = '0;
    repeat (2) @(negedge ClockIn);
    checkIdle("reset", 0, 0, 0);
    Reset = 1'b0;

    // single 1 Hz step of two ticks
    ProgSpeed = 8'b00_00_00_01; ProgDwell = 16'h0002;
    applyStimulus(1'b0, 0, 0);
    // full speed x3 then quarter speed x1
    ProgSpeed = 8'b00_00_11_00; ProgDwell = 16'h0013;
    applyStimulus(1'b0, 0, 0);
    // zero dwell on step 1 is skipped
    ProgSpeed = 8'b00_00_10_01; ProgDwell = 16'h0101;
    applyStimulus(1'b0, 0, 0);
    // looping at full speed wraps the counter, then halted
    ProgSpeed = 8'b00_00_00_00; ProgDwell = 16'hFFFF;
    applyStimulus(1'b1, 2, 130);

    // Start and Halt together in IDLE keep the sequencer idle
    @(negedge ClockIn);
    Start = 1'b1; Halt = 1'b1;
    @(negedge ClockIn);
    Start = 1'b0; Halt = 1'b0;
    checkIdle("starthalt", mStep, mSpeed, mCnt);

    for (int r = 0; r < 14; r++) begin
      ProgSpeed = 8'($urandom);
      for (int s = 0; s < STEPS; s++)
        ProgDwell[DWW*s +: DWW] = ($urandom % 4 == 0) ? 4'd0 : 4'($urandom_range(1, 6));
      if (r % 4 == 3) applyStimulus(1'b1, 2, 300);
      else            applyStimulus(1'b0, 1, 0);
    end

    // asynchronous reset between edges in the middle of a run
    ProgSpeed = 8'b01_01_01_01; ProgDwell = 16'h3333;
    @(negedge ClockIn);
    Start = 1'b1; Loop = 1'b0;
    @(negedge ClockIn);
    Start = 1'b0;
    repeat (12) @(negedge ClockIn);
    checkOutput("prereset_busy", 32'(Busy), 1);
    @(posedge ClockIn);
    #2 Reset = 1'b1;
    #1 checkIdle("asyncreset", 0, 0, 0);
    @(negedge ClockIn);
    Reset = 1'b0;
    @(negedge ClockIn);
    checkIdle("postreset", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
